spi_slave_if: RTL

- SPI slave front end that deframes messages from the host microcontroller into command/payload form for the register block downstream.
- First byte of each message is the command. Up to 8 following bytes fill a 64-bit payload.
- Emits a one-cycle message-end strobe when chip select is released.
- Shifts optional 64-bit response data out on MISO.

---
 rtl/spi_slave_if_pkg.sv | 19 +
 rtl/spi_slave_if_if.sv | 27 ++
 rtl/spi_slave_if_sync_edge.sv | 35 +++
 rtl/spi_slave_if.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/spi_slave_if_pkg.sv
// Shared types and constants for the SPI slave front end.
// Command codes are the byte values the host sends as the first byte of a message.
package spi_slave_if_pkg;

  localparam int PAYLOAD_W      = 64;
  localparam int MAX_DATA_BYTES = 8;

  localparam logic [7:0] CMD_RESET          = 8'h01;
  localparam logic [7:0] CMD_SET_KEY_MATRIX = 8'h10;
  localparam logic [7:0] CMD_WRITE_KBBUF16  = 8'h13;

  typedef enum logic [1:0] {
    S_RESYNC = 2'd0,
    S_IDLE   = 2'd1,
    S_CMD    = 2'd2,
    S_DATA   = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_slave_if_if.sv
// SPI pins plus the command/payload bus towards the register block.
// The slave modport is the view taken by spi_slave_if.
interface spi_slave_if_if;
  import spi_slave_if_pkg::*;

  logic                 spi_sclk;
  logic                 spi_ssel_n;
  logic                 spi_mosi;
  logic                 spi_miso;
  logic                 spi_miso_oe;
  logic                 spi_msg_end;
  logic [7:0]           spi_cmd;
  logic [PAYLOAD_W-1:0] spi_rxdata;
  logic [PAYLOAD_W-1:0] spi_txdata;
  logic                 spi_txdata_valid;

  modport slave (
    input  spi_sclk, spi_ssel_n, spi_mosi, spi_txdata, spi_txdata_valid,
    output spi_miso, spi_miso_oe, spi_msg_end, spi_cmd, spi_rxdata
  );

  modport master (
    output spi_sclk, spi_ssel_n, spi_mosi, spi_txdata, spi_txdata_valid,
    input  spi_miso, spi_miso_oe, spi_msg_end, spi_cmd, spi_rxdata
  );

endinterface

// File: rtl/spi_slave_if_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI input, with rise/fall detect
// taken from the last two synchronised samples.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_r;
  logic              q_d;

  // Chain resets to 0 so a chip select held low across reset never shows a
  // spurious high (and a later falling edge) that would let us join mid-message.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= '0;
      q_d    <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
      q_d    <= sync_r[STAGES-1];
    end
  end

  assign q    = sync_r[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave: deframes command byte + up to 8 payload bytes, strobes at
// chip-select release, and shifts a 64-bit response out on MISO.
module spi_slave_if
  import spi_slave_if_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  spi_slave_if_if.slave bus
);

  // state    | meaning
  // S_RESYNC | after reset, wait for ssel_n high before accepting a message
  // S_IDLE   | deselected, waiting for ssel_n falling
  // S_CMD    | shifting in the command byte
  // S_DATA   | shifting in payload bytes, shifting out response bits

  logic sclk_q, sclk_rise, sclk_fall;
  logic ssel_q, ssel_rise, ssel_fall;
  logic mosi_q, mosi_rise, mosi_fall;
  logic unused_sync_outs;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(bus.spi_sclk),
    .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ssel (
    .clk(clk), .reset(reset), .din(bus.spi_ssel_n),
    .q(ssel_q), .rise(ssel_rise), .fall(ssel_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(bus.spi_mosi),
    .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sync_outs = sclk_q ^ mosi_rise ^ mosi_fall;

  spi_state_t           state, state_nx;
  logic [2:0]           bit_cnt;
  logic [3:0]           byte_cnt;
  logic [7:0]           rx_shift;
  logic [7:0]           rx_byte;
  logic [PAYLOAD_W-1:0] tx_shift;
  logic [7:0]           cmd_r;
  logic [PAYLOAD_W-1:0] rxdata_r;
  logic                 msg_end_r;
  logic                 tx_load;
  logic                 skip_fall;

  logic sclk_rise_v, sclk_fall_v;
  logic do_start, do_shift_in, cmd_done, data_done, tx_shift_en, msg_end_nx;

  // SCLK activity while deselected is noise and never reaches the FSM.
  assign sclk_rise_v = sclk_rise & ~ssel_q;
  assign sclk_fall_v = sclk_fall & ~ssel_q;
  assign rx_byte     = {rx_shift[6:0], mosi_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RESYNC;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    do_start    = 1'b0;
    do_shift_in = 1'b0;
    cmd_done    = 1'b0;
    data_done   = 1'b0;
    tx_shift_en = 1'b0;
    msg_end_nx  = 1'b0;
    unique case (state)
      S_RESYNC: begin
        if (ssel_q) state_nx = S_IDLE;
      end
      S_IDLE: begin
        if (ssel_fall) begin
          do_start = 1'b1;
          state_nx = S_CMD;
        end
      end
      S_CMD: begin
        if (ssel_rise) begin
          state_nx = S_IDLE;
        end else if (sclk_rise_v) begin
          do_shift_in = 1'b1;
          if (bit_cnt == 3'd7) begin
            cmd_done = 1'b1;
            state_nx = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (ssel_rise) begin
          state_nx   = S_IDLE;
          msg_end_nx = 1'b1;
        end else begin
          if (sclk_rise_v) begin
            do_shift_in = 1'b1;
            data_done   = (bit_cnt == 3'd7);
          end
          tx_shift_en = sclk_fall_v;
        end
      end
      default: state_nx = S_RESYNC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      cmd_r     <= '0;
      rxdata_r  <= '0;
      msg_end_r <= 1'b0;
      tx_load   <= 1'b0;
      skip_fall <= 1'b0;
    end else begin
      msg_end_r <= msg_end_nx;
      tx_load   <= cmd_done;

      if (do_start) begin
        bit_cnt   <= '0;
        byte_cnt  <= '0;
        rx_shift  <= '0;
        tx_shift  <= '0;
        skip_fall <= 1'b0;
      end

      if (do_shift_in) begin
        rx_shift <= rx_byte;
        bit_cnt  <= bit_cnt + 3'd1;
      end

      if (cmd_done) begin
        cmd_r     <= rx_byte;
        rxdata_r  <= '0;
        skip_fall <= 1'b1;
      end

      if (data_done && !byte_cnt[3]) begin
        for (int i = 0; i < MAX_DATA_BYTES; i++) begin
          if (byte_cnt[2:0] == i[2:0]) rxdata_r[PAYLOAD_W-1-8*i -: 8] <= rx_byte;
        end
        byte_cnt <= byte_cnt + 4'd1;
      end

      if (tx_load) begin
        tx_shift <= bus.spi_txdata_valid ? bus.spi_txdata : '0;
      end else if (tx_shift_en) begin
        // The first fall after the command byte only sets up bit 63.
        if (skip_fall) skip_fall <= 1'b0;
        else           tx_shift  <= {tx_shift[PAYLOAD_W-2:0], 1'b0};
      end
    end
  end

  assign bus.spi_miso    = tx_shift[PAYLOAD_W-1];
  assign bus.spi_miso_oe = ~ssel_q & (state != S_RESYNC);
  assign bus.spi_msg_end = msg_end_r;
  assign bus.spi_cmd     = cmd_r;
  assign bus.spi_rxdata  = rxdata_r;

endmodule
